// File: rtl/uart_pkg.sv
// Shared constants, state encodings and the parity helper for the pixel UART sender.
package uart_pkg;

  localparam int PARITY_NONE     = 0;
  localparam int PARITY_EVEN     = 1;
  localparam int PARITY_ODD      = 2;
  localparam int DEFAULT_CLK_DIV = 868;

  // Character-level states, owned by uart_tx_frame.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Pixel-level sequencer states, owned by the top.
  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_LOAD,
    SEQ_SEND
  } seq_state_e;

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Serialises one UART character: start bit, 8 data bits LSB first, optional parity, stop bits.
// i_start is accepted when idle or in the final stop cycle, so characters can run back to back.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e   r_state;
  uart_state_e   w_state_next;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          w_bit_end;
  logic          w_last_data;
  logic          w_last_stop;
  logic          w_load;

  assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
  assign w_last_data = w_bit_end && (r_bit_cnt == 3'd7);
  assign w_last_stop = w_bit_end && (r_bit_cnt == STOP_LAST);
  assign w_load      = i_start && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last_stop));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_START;
      ST_START:  if (w_bit_end) w_state_next = ST_DATA;
      ST_DATA:   if (w_last_data) w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_state_next = ST_STOP;
      ST_STOP:   if (w_last_stop) w_state_next = i_start ? ST_START : ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx   = 1'b1;
    o_done = 1'b0;
    case (r_state)
      ST_START:  o_tx = 1'b0;
      ST_DATA:   o_tx = r_shift[0];
      ST_PARITY: o_tx = r_parity;
      ST_STOP:   o_done = w_last_stop;
      default:   ;
    endcase
  end

  // Bit counter restarts on every state change; it counts data bits in DATA and stop bits in STOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) || w_bit_end) r_baud_cnt <= '0;
      else                                   r_baud_cnt <= r_baud_cnt + 1'b1;

      if ((w_state_next != r_state) || w_load) r_bit_cnt <= '0;
      else if (w_bit_end)                      r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_load) begin
        r_shift  <= i_data;
        r_parity <= parity_bit(i_data, PARITY);
      end else if ((r_state == ST_DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
      end
    end
  end

endmodule

// File: rtl/uart_pixel_sender.sv
// Pixel FIFO plus byte sequencer in front of uart_tx_frame.
// Each pixel is split into bytes sent without gaps; pixel_sent pulses once per pixel.
module uart_pixel_sender
  import uart_pkg::*;
#(
  parameter int PIXEL_W        = 8,
  parameter int DEPTH          = 16,
  parameter int CLK_DIV        = DEFAULT_CLK_DIV,
  parameter int PARITY         = PARITY_NONE,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PIXEL_W-1:0]       in_data,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     pixel_sent
);

  localparam int             BYTES     = PIXEL_W / 8;
  localparam int             AW        = $clog2(DEPTH);
  localparam int             CNTW      = AW + 1;
  localparam int             BW        = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0]  LAST_BYTE = BW'(BYTES - 1);
  localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);

  logic [PIXEL_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNTW-1:0]    r_count;
  seq_state_e         r_state;
  seq_state_e         w_state_next;
  logic [PIXEL_W-1:0] r_pixel;
  logic [BW-1:0]      r_byte_idx;
  logic               r_pixel_sent;

  logic               w_push;
  logic               w_pop;
  logic               w_frame_start;
  logic               w_frame_done;
  logic               w_last_byte;
  logic               w_pixel_done;
  logic               w_next_byte_go;
  logic [PIXEL_W-1:0] w_head;
  logic [PIXEL_W-1:0] w_pixel_shifted;
  logic [7:0]         w_first_byte;
  logic [7:0]         w_next_byte;
  logic [7:0]         w_frame_data;

  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];
  assign in_ready = (r_count != FULL);

  // The byte on the wire always sits at the "front" of r_pixel; advancing shifts it out.
  if (MSB_BYTE_FIRST != 0) begin : g_msb_first
    assign w_pixel_shifted = r_pixel << 8;
    assign w_first_byte    = w_head[PIXEL_W-1 -: 8];
    assign w_next_byte     = w_pixel_shifted[PIXEL_W-1 -: 8];
  end else begin : g_lsb_first
    assign w_pixel_shifted = r_pixel >> 8;
    assign w_first_byte    = w_head[7:0];
    assign w_next_byte     = w_pixel_shifted[7:0];
  end

  assign w_last_byte    = (r_byte_idx == LAST_BYTE);
  assign w_pixel_done   = (r_state == SEQ_SEND) && w_frame_done && w_last_byte;
  assign w_next_byte_go = (r_state == SEQ_SEND) && w_frame_done && !w_last_byte;
  assign w_frame_data   = (r_state == SEQ_LOAD) ? w_first_byte : w_next_byte;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SEQ_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE: if (r_count != '0) w_state_next = SEQ_LOAD;
      SEQ_LOAD: w_state_next = SEQ_SEND;
      SEQ_SEND: if (w_pixel_done) w_state_next = (r_count != '0) ? SEQ_LOAD : SEQ_IDLE;
      default:  w_state_next = SEQ_IDLE;
    endcase
  end

  always_comb begin
    w_pop         = 1'b0;
    w_frame_start = w_next_byte_go;
    busy          = (r_count != '0);
    case (r_state)
      SEQ_LOAD: begin
        w_pop         = 1'b1;
        w_frame_start = 1'b1;
        busy          = 1'b1;
      end
      SEQ_SEND: busy = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pixel      <= '0;
      r_byte_idx   <= '0;
      r_pixel_sent <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pixel    <= w_head;
        r_byte_idx <= '0;
      end else if (w_next_byte_go) begin
        r_pixel    <= w_pixel_shifted;
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      r_pixel_sent <= w_pixel_done;
    end
  end

  assign fifo_count = r_count;
  assign pixel_sent = r_pixel_sent;

  uart_tx_frame #(
    .CLK_DIV  (CLK_DIV),
    .PARITY   (PARITY),
    .STOP_BITS(STOP_BITS)
  ) u_frame (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_frame_start),
    .i_data (w_frame_data),
    .o_tx   (tx),
    .o_done (w_frame_done)
  );

endmodule

// File: tb/tb_uart_pixel_sender.sv
// Bench for uart_pixel_sender: three configurations share one clock; a line monitor
// decodes tx frames and compares them against a scoreboard queue of expected frames.
module tb_uart_pixel_sender;

  localparam int CD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // A: 8-bit, DEPTH 4, no parity, 1 stop
  logic       a_rst_n, a_valid, a_ready, a_tx, a_busy, a_ps;
  logic [7:0] a_data;
  logic [2:0] a_cnt;
  // B: 16-bit, MSB byte first, even parity
  logic        b_rst_n, b_valid, b_ready, b_tx, b_busy, b_ps;
  logic [15:0] b_data;
  logic [4:0]  b_cnt;
  // C: 8-bit, odd parity, 2 stop bits
  logic       c_rst_n, c_valid, c_ready, c_tx, c_busy, c_ps;
  logic [7:0] c_data;
  logic [4:0] c_cnt;

  uart_pixel_sender #(.PIXEL_W(8), .DEPTH(4), .CLK_DIV(CD), .PARITY(0), .STOP_BITS(1), .MSB_BYTE_FIRST(0)) dut_a (
    .clk(clk), .rst(a_rst_n), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .tx(a_tx), .busy(a_busy), .fifo_count(a_cnt), .pixel_sent(a_ps));
  uart_pixel_sender #(.PIXEL_W(16), .DEPTH(16), .CLK_DIV(CD), .PARITY(1), .STOP_BITS(1), .MSB_BYTE_FIRST(1)) dut_b (
    .clk(clk), .rst(b_rst_n), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .tx(b_tx), .busy(b_busy), .fifo_count(b_cnt), .pixel_sent(b_ps));
  uart_pixel_sender #(.PIXEL_W(8), .DEPTH(16), .CLK_DIV(CD), .PARITY(2), .STOP_BITS(2), .MSB_BYTE_FIRST(0)) dut_c (
    .clk(clk), .rst(c_rst_n), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .tx(c_tx), .busy(c_busy), .fifo_count(c_cnt), .pixel_sent(c_ps));

  logic [2:0] tx_v;
  logic [2:0] ready_v;
  assign tx_v    = {c_tx, b_tx, a_tx};
  assign ready_v = {c_ready, b_ready, a_ready};

  int ps_a = 0, ps_b = 0, ps_c = 0;
  always @(negedge clk) begin
    if (a_ps) ps_a <= ps_a + 1;
    if (b_ps) ps_b <= ps_b + 1;
    if (c_ps) ps_c <= ps_c + 1;
  end

  typedef struct {
    int          nbits;
    logic [11:0] bits;   // bit 0 is the first bit on the wire
  } frame_t;

  typedef struct {
    logic [7:0]  pix;
    logic [11:0] frame;
  } vec_t;

  frame_t sb_q[$];
  int     gap_log[8];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic exp_frame(input int nbits, input logic [11:0] bits);
    frame_t fr;
    fr.nbits = nbits;
    fr.bits  = bits;
    sb_q.push_back(fr);
  endtask

  // Offer one pixel from a negedge; returns at the negedge after it was accepted.
  task automatic push(input int dut, input logic [15:0] d, output int stalls);
    stalls = 0;
    case (dut)
      0:       begin a_valid = 1'b1; a_data = d[7:0]; end
      1:       begin b_valid = 1'b1; b_data = d;      end
      default: begin c_valid = 1'b1; c_data = d[7:0]; end
    endcase
    while (ready_v[dut] !== 1'b1 && stalls < 3000) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 3000) begin
      checks++; errors++;
      $display("FAIL push_timeout: dut %0d never ready, got ready=0 required ready=1", dut);
    end
    @(negedge clk);
    $display("push dut %0d data %0h after %0d stall cycles", dut, d, stalls);
  endtask

  // Decode nframes frames on tx_v[dut]; every bit must hold for CD cycles.
  task automatic mon_frames(input int dut, input int nframes);
    for (int f = 0; f < nframes; f++) begin
      frame_t      e;
      logic [11:0] got;
      int          w;
      bit          stable;
      w = 0;
      while (tx_v[dut] !== 1'b0 && w < 3000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 3000) begin
        checks++; errors++;
        $display("FAIL start_timeout: dut %0d frame %0d got no start bit, required one", dut, f);
        return;
      end
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: dut %0d frame %0d got a frame, required none", dut, f);
        return;
      end
      e = sb_q.pop_front();
      gap_log[f] = w;
      got    = '0;
      stable = 1'b1;
      for (int k = 0; k < e.nbits; k++) begin
        got[k] = tx_v[dut];
        for (int c = 1; c < CD; c++) begin
          @(negedge clk);
          if (tx_v[dut] !== got[k]) stable = 1'b0;
        end
        if (k != e.nbits - 1) @(negedge clk);
      end
      $display("frame dut %0d #%0d: got %03h expected %03h gap %0d", dut, f, got, e.bits, w);
      check("frame_bits", 32'(got), 32'(e.bits));
      check("bit_width", 32'(stable), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [9:0]  f10;
    logic        exp_tx;
    int          ps0, st, first_stall, max_cnt;
    bit          mon_done;

    tbl[0] = '{pix: 8'h3C, frame: 12'({1'b1, 8'h3C, 1'b0})};
    tbl[1] = '{pix: 8'h81, frame: 12'({1'b1, 8'h81, 1'b0})};
    tbl[2] = '{pix: 8'h00, frame: 12'({1'b1, 8'h00, 1'b0})};
    tbl[3] = '{pix: 8'hFF, frame: 12'({1'b1, 8'hFF, 1'b0})};
    tbl[4] = '{pix: 8'h6E, frame: 12'({1'b1, 8'h6E, 1'b0})};
    tbl[5] = '{pix: 8'hD2, frame: 12'({1'b1, 8'hD2, 1'b0})};

    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    repeat (3) @(negedge clk);
    check("in_reset_a", 32'({a_tx, a_ready, a_busy, a_cnt, a_ps}), 32'({1'b1, 1'b1, 1'b0, 3'd0, 1'b0}));
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

    // Idle after reset
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      check("idle_a", 32'({a_tx, a_ready, a_busy, a_cnt, a_ps}), 32'({1'b1, 1'b1, 1'b0, 3'd0, 1'b0}));
    end
    check("idle_b", 32'({b_tx, b_ready, b_busy, b_cnt}), 32'({1'b1, 1'b1, 1'b0, 5'd0}));
    check("idle_c", 32'({c_tx, c_ready, c_busy, c_cnt}), 32'({1'b1, 1'b1, 1'b0, 5'd0}));

    // Single pixel 0xA5, cycle-exact: t counts negedges after the push edge
    ps0 = ps_a;
    f10 = {1'b1, 8'hA5, 1'b0};
    a_valid = 1'b1;
    a_data  = 8'hA5;
    @(negedge clk);
    a_valid = 1'b0;
    for (int t = 1; t <= 50; t++) begin
      exp_tx = (t < 3 || t > 42) ? 1'b1 : f10[(t - 3) / 4];
      check("a5_tx", 32'(a_tx), 32'(exp_tx));
      check("a5_pixel_sent", 32'(a_ps), 32'(t == 43));
      check("a5_busy", 32'(a_busy), 32'(t <= 42));
      check("a5_count", 32'(a_cnt), (t < 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("a5_sent_total", 32'(ps_a - ps0), 32'd1);

    // 16-bit MSB-first with even parity: 0x12 then 0x34, back to back
    ps0 = ps_b;
    exp_frame(11, 12'({1'b1, 1'b0, 8'h12, 1'b0}));
    exp_frame(11, 12'({1'b1, 1'b1, 8'h34, 1'b0}));
    fork
      begin push(1, 16'h1234, st); b_valid = 1'b0; end
      mon_frames(1, 2);
    join
    check("b_no_byte_gap", 32'(gap_log[1]), 32'd1);
    repeat (4) @(negedge clk);
    check("b_sent_total", 32'(ps_b - ps0), 32'd1);
    check("b_idle_after", 32'({b_busy, b_tx}), 32'({1'b0, 1'b1}));

    // Odd parity, two stop bits
    ps0 = ps_c;
    exp_frame(12, 12'({2'b11, 1'b1, 8'hFF, 1'b0}));
    exp_frame(12, 12'({2'b11, 1'b1, 8'h00, 1'b0}));
    exp_frame(12, 12'({2'b11, 1'b0, 8'h01, 1'b0}));
    fork
      begin
        push(2, 16'h00FF, st);
        push(2, 16'h0000, st);
        push(2, 16'h0001, st);
        c_valid = 1'b0;
      end
      mon_frames(2, 3);
    join
    check("c_load_gap", 32'(gap_log[1]), 32'd2);
    repeat (4) @(negedge clk);
    check("c_sent_total", 32'(ps_c - ps0), 32'd3);

    // DEPTH 4 burst of six with valid held: five accepted before the first stall
    ps0 = ps_a;
    first_stall = -1;
    max_cnt = 0;
    mon_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          exp_frame(10, tbl[i].frame);
          push(0, {8'h00, tbl[i].pix}, st);
          if (st != 0 && first_stall < 0) first_stall = i;
        end
        a_valid = 1'b0;
      end
      begin mon_frames(0, 6); mon_done = 1'b1; end
      begin
        while (!mon_done) begin
          @(negedge clk);
          if (int'(a_cnt) > max_cnt) max_cnt = int'(a_cnt);
        end
      end
    join
    check("burst_first_stall", 32'(first_stall), 32'd5);
    check("burst_max_count", 32'(max_cnt), 32'd4);
    for (int f = 1; f < 6; f++) check("burst_load_gap", 32'(gap_log[f]), 32'd2);
    repeat (4) @(negedge clk);
    check("burst_sent_total", 32'(ps_a - ps0), 32'd6);
    check("burst_idle", 32'({a_busy, a_cnt}), 32'd0);

    // Reset in the middle of a 3-pixel burst
    push(0, 16'h0011, st);
    push(0, 16'h0022, st);
    push(0, 16'h0033, st);
    a_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_tx_data0", 32'(a_tx), 32'd0);
    check("pre_reset_busy", 32'(a_busy), 32'd1);
    a_rst_n = 1'b0;
    #1;
    check("reset_now", 32'({a_tx, a_ready, a_busy, a_cnt, a_ps}), 32'({1'b1, 1'b1, 1'b0, 3'd0, 1'b0}));
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;
    ps0 = ps_a;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      check("post_reset_quiet", 32'({a_tx, a_busy, a_cnt}), 32'({1'b1, 1'b0, 3'd0}));
    end
    check("post_reset_no_sent", 32'(ps_a - ps0), 32'd0);
    exp_frame(10, 12'({1'b1, 8'h5A, 1'b0}));
    fork
      begin push(0, 16'h005A, st); a_valid = 1'b0; end
      mon_frames(0, 1);
    join
    check("post_reset_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
